// File: rtl/sram_pkg.sv
// Shared widths, types and FSM states for the SRAM responder.
package sram_pkg;
  localparam int SRAM_AW = 15;
  localparam int SRAM_DW = 256;

  typedef logic [SRAM_AW-1:0] sram_addr_t;
  typedef logic [SRAM_DW-1:0] sram_data_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_rsp_state_e;
endpackage

// File: rtl/sram_responder_if.sv
// SRAM request/response bundle: the driver is master, the responder is slave.
interface sram_responder_if
  import sram_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
);
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          wen;
  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          init_done;
  logic          err_drop;

  modport master (
    output req, addr, din, wen,
    input  busy, dout, dout_valid, init_done, err_drop
  );

  modport slave (
    input  req, addr, din, wen,
    output busy, dout, dout_valid, init_done, err_drop
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read-data delay line of READ_LAT-1 stages; the responder's output register adds the last cycle.
// Only valid bits are reset; each data stage loads only when its incoming valid is set.
module sram_rd_pipe #(
  parameter int DW       = 256,
  parameter int READ_LAT = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [DW-1:0] out_dat
);
  localparam int STAGES = READ_LAT - 1;

  generate
    if (STAGES == 0) begin : g_pass
      assign out_vld = in_vld;
      assign out_dat = in_dat;
    end else begin : g_pipe
      logic [STAGES-1:0] vld;
      logic [DW-1:0]     dat [STAGES];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld <= '0;
        end else begin
          vld[0] <= in_vld;
          for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (in_vld) dat[0] <= in_dat;
        for (int i = 1; i < STAGES; i++) begin
          if (vld[i-1]) dat[i] <= dat[i-1];
        end
      end

      assign out_vld = vld[STAGES-1];
      assign out_dat = dat[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/sram_responder.sv
// SRAM target: zero-fills the array after reset (busy high), then takes one request per cycle.
// Writes land at the accepting edge; reads return after READ_LAT cycles; requests seen while busy are dropped.
module sram_responder
  import sram_pkg::*;
#(
  parameter int AW             = SRAM_AW,
  parameter int DW             = SRAM_DW,
  parameter int READ_LAT       = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rstn,
  sram_responder_if.slave bus
);
  localparam logic [AW-1:0] LAST_ADDR = '1;

  sram_rsp_state_e state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic [DW-1:0]   mem [2**AW];

  logic            clr_we;
  logic            accept;
  logic            mem_we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            pipe_vld;
  logic [DW-1:0]   pipe_dat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Without clearing, INIT is a single pass-through cycle so busy drops on the first edge.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    case (state)
      INIT: begin
        clr_we = (CLEAR_ON_RESET != 0);
        if (CLEAR_ON_RESET == 0 || clr_cnt == LAST_ADDR) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  assign bus.busy      = (state != READY);
  assign bus.init_done = (state == READY);
  assign accept        = bus.req && !bus.busy;

  always_comb begin
    mem_we = clr_we || (accept && bus.wen);
    waddr  = clr_we ? clr_cnt : bus.addr;
    wdata  = clr_we ? '0 : bus.din;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  sram_rd_pipe #(
    .DW       (DW),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (accept && !bus.wen),
    .in_dat  (mem[bus.addr]),
    .out_vld (pipe_vld),
    .out_dat (pipe_dat)
  );

  // dout keeps the last returned word between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.dout_valid <= 1'b0;
      bus.dout       <= '0;
      bus.err_drop   <= 1'b0;
    end else begin
      bus.dout_valid <= pipe_vld;
      if (pipe_vld) bus.dout <= pipe_dat;
      bus.err_drop <= bus.req && bus.busy;
    end
  end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder model for the SRAM port. It is the memory side of the addr/din/wen request interface that the driver writes to.
- Accepts one request per cycle when not busy. Performs writes immediately and returns read data after a fixed, parameterized latency.
- After reset, it clears the whole array while holding busy high, then serves traffic.
- Sits in the bench/DUT harness as the SRAM target, and acts as the reference model for scoreboard checks.

Parameters:
- AW, 15, address width; array depth is 2**AW words.
- DW, 256, data word width.
- READ_LAT, 2, cycles from read acceptance to dout_valid; legal range 1..8.
- CLEAR_ON_RESET, 1, when 1 the array is zero-filled after reset; when 0, INIT is skipped.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req  input  1  request strobe, sampled at posedge clk
- addr  input  AW  request address
- din  input  DW  write data
- wen  input  1  1 = write, 0 = read
- busy  output  1  responder cannot accept requests
- dout  output  DW  read data
- dout_valid  output  1  dout holds valid read data this cycle
- init_done  output  1  array clear complete, sticky until reset
- err_drop  output  1  one-cycle pulse: req arrived while busy and was dropped

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk.
- Reset values:
  - busy=1, dout=0, dout_valid=0, init_done=0, err_drop=0.
  - Read pipeline valid bits = 0, clear counter = 0, state = INIT.
  - If CLEAR_ON_RESET=0, the first state after reset is READY with busy=0 and init_done=1.
- FSM has two states: INIT and READY.
  - INIT: each cycle writes 0 to mem[clr_cnt], then clr_cnt++.
  - When clr_cnt==2**AW-1 is written, transition to READY on the next edge.
  - INIT therefore lasts exactly 2**AW cycles.
  - busy=1 throughout INIT. init_done rises on the same edge busy falls.
  - READY: busy=0. This is a terminal state until reset.
- Acceptance: a request is accepted at a posedge when req=1 and busy=0 (registered busy).
- Write (wen=1): mem[addr] <= din at the accepting edge. There is no read response.
- Read (wen=0):
  - Array is read at the accepting edge.
  - Data and valid enter the READ_LAT-deep pipeline.
  - dout_valid=1 for exactly one cycle, READ_LAT cycles after acceptance.
- Back-to-back requests:
  - One request per cycle, sustained throughput 1; no stalls in READY.
  - Write at cycle N followed by read of the same addr at cycle N+1 returns the new data.
  - Array semantics are write-first across cycles; no same-cycle read/write is possible.
- dout holds the last returned read data when dout_valid=0; it never returns to 0 except on reset.
- Dropped requests:
  - req=1 while busy=1 causes err_drop=1 on the following cycle.
  - The request has no effect on the array or the pipeline.
- Address is used modulo 2**AW. No out-of-range case exists.
- X/Z on din during a write is stored as-is. No checking is done in RTL.
- Reset mid-operation:
  - All in-flight reads are discarded; dout_valid=0 immediately (async).
  - FSM returns to INIT and the clear restarts from address 0.
  - Array contents are undefined until init_done.

Decomposition:
- Package sram_pkg holds:
  - localparams SRAM_AW=15, SRAM_DW=256.
  - typedefs sram_addr_t, sram_data_t.
  - enum sram_rsp_state_e {INIT, READY}.
- Sub-module sram_rd_pipe (parameters DW, READ_LAT): valid/data shift register with async reset of the valid bits only.
- Top-level module contains: the FSM, the clear counter, the array, acceptance logic, and err_drop.

Test Plan:
- Run all scenarios with AW=4, READ_LAT=2.
1. Reset release, req=0 -> busy=1 for exactly 16 cycles, then busy=0 and init_done=1. A subsequent read of every address returns 0.
2. Write addr 3 din 0xA5A5, then read addr 3 the next cycle -> dout_valid pulses exactly 2 cycles after the read edge, with dout=0xA5A5.
3. Back-to-back reads of addrs 1, 2, 3 after writing 0x11, 0x22, 0x33 -> dout_valid high 3 consecutive cycles with dout 0x11, 0x22, 0x33. Afterwards dout holds 0x33 with dout_valid=0.
4. req=1 (write addr 5, 0xFF) at cycle 3 of INIT -> err_drop pulses 1 cycle. After init, a read of addr 5 returns 0.
5. Issue a read, then assert rstn=0 one cycle later -> dout_valid stays 0 and never fires. After release, busy=1 for 16 cycles again.
6. Set CLEAR_ON_RESET=0 -> busy=0 and init_done=1 on the first edge after reset. Writing addr 15 and reading it back returns the written value at latency 2.
